dmem_wait: RTL

Parametrised data-memory block for the single-cycle CPU computer top, replacing the fixed zero-latency word-only data memory. Adds byte/halfword/word access with sign or zero extension, a configurable wait-state count with a ready handshake so the CPU stalls on each access, and misalignment detection. Sits between the CPU data port and the on-chip data store.

---
 rtl/dmem_wait.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dmem_wait.sv
// Data memory with configurable wait states, byte/halfword/word lanes and
// misalignment detection. One request in flight; completion signalled by a ready pulse.
//
// state | meaning
// IDLE  | waiting for DM_CS with DM_R or DM_W; request latched on acceptance
// WAIT  | counting down wait states, inputs ignored
// DONE  | ready pulse, write committed at end of cycle, rdata/err valid
module dmem_wait #(
    parameter int ADDR_W      = 11,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DM_CS,
    input  logic        DM_R,
    input  logic        DM_W,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic              wr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem [2**ADDR_W];

    logic              req;
    logic              misaligned;
    logic              mem_we;
    logic [3:0]        lane_en;
    logic [31:0]       wlane;
    logic [31:0]       word;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [31:0]       rfmt;
    logic [ADDR_W-1:0] widx;
    logic              unused_addr_hi;

    // upper address bits wrap the array
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign req = DM_CS & (DM_R | DM_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                addr_q  <= addr[ADDR_W+1:0];
                size_q  <= size;
                sext_q  <= sign_ext;
                wr_q    <= DM_W;
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt   = 4'(WAIT_CYCLES);
                    state_nxt = (WAIT_CYCLES > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign widx       = addr_q[ADDR_W+1:2];
    assign misaligned = ((size_q == 2'b01) && addr_q[0]) ||
                        (size_q[1] && (addr_q[1:0] != 2'b00));
    assign mem_we     = (state == DONE) && wr_q && !misaligned;

    always_comb begin
        lane_en = 4'b1111;
        wlane   = wdata_q;
        case (size_q)
            2'b00: begin
                lane_en = 4'b0001 << addr_q[1:0];
                wlane   = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane   = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_en = 4'b1111;
                wlane   = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (lane_en[i])
                    mem[widx][8*i +: 8] <= wlane[8*i +: 8];
        end
    end

    assign word = mem[widx];

    always_comb begin
        rbyte = word[7:0];
        case (addr_q[1:0])
            2'b00:   rbyte = word[7:0];
            2'b01:   rbyte = word[15:8];
            2'b10:   rbyte = word[23:16];
            default: rbyte = word[31:24];
        endcase
        rhalf = addr_q[1] ? word[31:16] : word[15:0];
        case (size_q)
            2'b00:   rfmt = {{24{sext_q & rbyte[7]}}, rbyte};
            2'b01:   rfmt = {{16{sext_q & rhalf[15]}}, rhalf};
            default: rfmt = word;
        endcase
    end

    assign ready = (state == DONE);
    assign err   = ready && misaligned;
    assign busy  = (state != IDLE);
    assign rdata = (ready && !wr_q && !misaligned) ? rfmt : 32'd0;

endmodule
